multi_debounce_counter: RTL
===========================

// Module: multi_debounce_counter
// PURPOSE
//  N-channel debouncer and event counter: per channel, synchronise the raw input, filter it by stable time,
//  emit rise/fall ticks, and count both debounced and raw (bouncy) edges.
//  Sits between the board buttons and the display/counter logic; replaces the single-channel debounce pair.
// PARAMETERS
//  N_CH       4     number of independent input channels
//  DB_CYCLES  20'd500000  consecutive stable cycles required to accept a new level (>=2)
//  DB_W       20    width of the stable-time counter; 2**DB_W > DB_CYCLES
//  CNT_W      8     width of each event counter
//  SAT        0     1 = event counters saturate at all-ones; 0 = wrap to 0
//  RST_LEVEL  1     idle/reset level of inputs (buttons are active-low, so idle is 1)
// PORTS
//  clk        in   1            system clock
//  clr_n      in   1            asynchronous reset, active-low
//  din        in   N_CH         raw asynchronous inputs
//  mode       in   2*N_CH       per-channel edge select, ch i = mode[2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
//  cnt_clr    in   1            synchronous clear of all event counters
//  level      out  N_CH         debounced level
//  rise_tick  out  N_CH         one-cycle pulse on each debounced 0->1
//  fall_tick  out  N_CH         one-cycle pulse on each debounced 1->0
//  db_count   out  N_CH*CNT_W   debounced edge count, ch i = [i*CNT_W +: CNT_W]
//  raw_count  out  N_CH*CNT_W   raw synchronised edge count, same packing
// BEHAVIOUR
//  Reset (clr_n=0, async): sync FFs, level = RST_LEVEL; stable counter, ticks and both counts = 0.
//  Sync: 2-FF synchroniser per channel; s = 2nd stage. s lags din by 2 edges.
//  Debounce, per channel, on each clk edge:
//   - s == level: stable counter cleared.
//   - s != level and counter < DB_CYCLES-1: counter increments.
//   - s != level and counter == DB_CYCLES-1: level <= s, counter cleared, matching tick asserted the same edge.
//   - level therefore changes exactly DB_CYCLES edges after s first differs and stays differing.
//   - Any glitch back to level before then restarts the count (no partial credit).
//  Ticks: registered, high for exactly one cycle, coincident with the first cycle of the new level.
//   rise_tick and fall_tick are never high together on a channel.
//  Raw edge: s differs from its previous sample (3rd register); polarity is taken from s.
//  Counting, per channel, by mode:
//   - db_count increments on each selected tick.
//   - raw_count increments on each selected raw edge.
//   - mode 00 freezes both counts.
//   - mode is sampled on the same edge as the event; a mode change takes effect immediately.
//   - Overflow: SAT=0 wraps all-ones -> 0; SAT=1 holds at all-ones.
//   - cnt_clr=1 zeroes all counts that edge and has priority over a simultaneous increment.
//     Debounce state and level are not affected.
//  Outputs are direct register outputs; there are no combinational paths from inputs.
//  Reset mid-debounce discards the partial count; no tick is issued on reset release.
//   Inputs held at the non-idle level across reset release produce one normal edge DB_CYCLES+2 cycles later.
// STRUCTURE
//  Shared package/header: mode encodings (MODE_NONE/RISE/FALL/BOTH) and a counter-increment function
//   honouring SAT.
//  Sub-module db_channel: sync + stable counter + level/ticks + raw-edge detect for one channel.
//   Instantiated N_CH times in a generate loop; the top holds the counters, mode decode and output packing.
// TESTING (sim with N_CH=2, DB_CYCLES=4, DB_W=3, CNT_W=4, RST_LEVEL=1, mode=2'b10 unless noted)
//  1 Reset: clr_n=0 with din toggling.
//    -> level=2'b11, ticks 0, counts 0.
//    Release with din=2'b11 -> no tick for 20 cycles.
//  2 Clean press: din[0] 1->0 held.
//    -> fall_tick[0] high exactly once, 6 edges after din change.
//    -> level[0]=0 the same cycle; db_count[0]=1, raw_count[0]=1.
//  3 Bounce: din[0] toggles 0,1,0,1,0 at 2-cycle spacing, then holds 0.
//    -> raw_count[0]=3, db_count[0]=1, one fall_tick only.
//  4 Glitch: din[0]=0 for 3 cycles, then back to 1.
//    -> level[0] stays 1; no tick; raw_count[0]=1.
//  5 Overflow: 17 clean presses.
//    SAT=0 -> db_count[0]=1; SAT=1 -> db_count[0]=4'hF.
//  6 Clear and mode: cnt_clr asserted on a tick cycle -> count 0.
//    mode[1:0]=11 -> press+release adds 2; mode=00 adds 0.
//    Channel 1 counts are unaffected by channel 0 activity.

Source files
------------

// File: rtl/multi_debounce_counter_pkg.sv
// multi_debounce_counter_pkg: shared mode encodings and counter-increment helper
package multi_debounce_counter_pkg;
  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // Increment a w-bit value held in 32 bits, either wrapping or holding at all-ones
  function automatic logic [31:0] cnt_inc(input logic [31:0] v, input int w, input bit sat);
    logic [31:0] ones;
    ones = (32'h1 << w) - 32'h1;
    return (sat && v == ones) ? v : ((v + 32'h1) & ones);
  endfunction
endpackage

// File: rtl/multi_debounce_counter_db_channel.sv
// db_channel: one-channel synchroniser, stable-time filter, level/ticks and raw-edge detect
module db_channel
  import multi_debounce_counter_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 20,
  parameter bit          RST_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic clr_n,
  input  logic din,
  output logic level,
  output logic rise_tick,
  output logic fall_tick,
  output logic raw_rise,
  output logic raw_fall
);
  localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);
  logic sync1_q, s_q, s_prev_q, level_q, rise_q, fall_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic differ, done;
  assign differ = s_q != level_q;
  assign done   = differ && cnt_q == LAST;
  assign cnt_d  = (differ && !done) ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q  <= RST_LEVEL;
      s_q      <= RST_LEVEL;
      s_prev_q <= RST_LEVEL;
      level_q  <= RST_LEVEL;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= din;
      s_q      <= sync1_q;
      s_prev_q <= s_q;
      cnt_q    <= cnt_d;
      level_q  <= done ? s_q : level_q;
      rise_q   <= done && s_q;
      fall_q   <= done && !s_q;
    end
  end
  assign level     = level_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  // Raw edges are seen while s differs from its delayed copy, i.e. for one cycle
  assign raw_rise  = s_q & ~s_prev_q;
  assign raw_fall  = ~s_q & s_prev_q;
endmodule

// File: rtl/multi_debounce_counter.sv
// multi_debounce_counter: N-channel debouncer with per-channel debounced and raw edge counters
module multi_debounce_counter
  import multi_debounce_counter_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 20,
  parameter int unsigned CNT_W     = 8,
  parameter bit          SAT       = 1'b0,
  parameter bit          RST_LEVEL = 1'b1
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic [N_CH-1:0]         din,
  input  logic [2*N_CH-1:0]       mode,
  input  logic                    cnt_clr,
  output logic [N_CH-1:0]         level,
  output logic [N_CH-1:0]         rise_tick,
  output logic [N_CH-1:0]         fall_tick,
  output logic [N_CH*CNT_W-1:0]   db_count,
  output logic [N_CH*CNT_W-1:0]   raw_count
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mode_e m;
    logic rise_sel, fall_sel, raw_rise, raw_fall, db_inc, raw_inc;
    logic [CNT_W-1:0] db_q, db_d, raw_q, raw_d;
    db_channel #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .RST_LEVEL(RST_LEVEL)) u_ch (
      .clk       (clk),
      .clr_n     (clr_n),
      .din       (din[g]),
      .level     (level[g]),
      .rise_tick (rise_tick[g]),
      .fall_tick (fall_tick[g]),
      .raw_rise  (raw_rise),
      .raw_fall  (raw_fall)
    );
    assign m        = mode_e'(mode[2*g +: 2]);
    assign rise_sel = m == MODE_RISE || m == MODE_BOTH;
    assign fall_sel = m == MODE_FALL || m == MODE_BOTH;
    assign db_inc   = (rise_tick[g] && rise_sel) || (fall_tick[g] && fall_sel);
    assign raw_inc  = (raw_rise && rise_sel) || (raw_fall && fall_sel);
    // Clear beats a simultaneous increment
    assign db_d  = cnt_clr ? '0 : db_inc ? CNT_W'(cnt_inc(32'(db_q), CNT_W, SAT)) : db_q;
    assign raw_d = cnt_clr ? '0 : raw_inc ? CNT_W'(cnt_inc(32'(raw_q), CNT_W, SAT)) : raw_q;
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        db_q  <= '0;
        raw_q <= '0;
      end else begin
        db_q  <= db_d;
        raw_q <= raw_d;
      end
    end
    assign db_count[g*CNT_W +: CNT_W]  = db_q;
    assign raw_count[g*CNT_W +: CNT_W] = raw_q;
  end
endmodule
